// File: rtl/i2c_pkg.sv
// Shared types and constants for the 10-bit-address I2C initiator.
// The frame layout (prefix byte, low address, register, data) lives here.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_TX_BYTE,
        ST_RX_ACK,
        ST_RX_BYTE,
        ST_TX_NACK,
        ST_STOP,
        ST_DONE,
        ST_GAP
    } state_e;

    localparam logic [4:0] ADDR10_PREFIX    = 5'b11110;
    localparam int         BYTES_PER_XFER   = 4;
    localparam int         QUARTERS_PER_BIT = 4;

    function automatic logic [7:0] frame_byte(input logic [1:0] idx,
                                              input logic       rw,
                                              input logic [9:0] slv,
                                              input logic [7:0] reg_a,
                                              input logic [7:0] wd);
        logic [7:0] b;
        case (idx)
            2'd0:    b = {ADDR10_PREFIX, slv[9:8], rw};
            2'd1:    b = slv[7:0];
            2'd2:    b = reg_a;
            default: b = wd;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-period timebase: one tick every CLK_DIV clocks plus a 2-bit
// quarter index; both held at zero whenever the master is not busy.
module i2c_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    output logic       tick_o,
    output logic [1:0] quarter_o
);
    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt_q;
    logic [1:0]    qtr_q;

    assign tick_o    = en_i && (cnt_q == CW'(CLK_DIV - 1));
    assign quarter_o = qtr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            cnt_q <= '0;
            qtr_q <= '0;
        end else if (tick_o) begin
            cnt_q <= '0;
            qtr_q <= qtr_q + 2'd1;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/i2c_master_10b.sv
// Single-transaction I2C initiator for 10-bit targets: START, 2 address
// bytes, register byte, one data byte written or read, STOP.
// Optional `I2C_RETRY_EN: re-run the frame after a NACK up to RETRY_MAX times.
module i2c_master_10b
    import i2c_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int RETRY_MAX = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       rw_i,
    input  logic [9:0] slv_addr_i,
    input  logic [7:0] reg_addr_i,
    input  logic [7:0] wdata_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       ack_err_o,
    output logic [7:0] rdata_o,
    inout  wire        sda_io,
    output logic       scl_o
);
    localparam int         RW        = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_XFER - 1);
    localparam logic [1:0] Q_LAST    = 2'(QUARTERS_PER_BIT - 1);

    state_e        state_q, state_d;
    logic          rw_q, rw_d;
    logic [9:0]    slv_q, slv_d;
    logic [7:0]    reg_q, reg_d, wd_q, wd_d;
    logic [1:0]    idx_q, idx_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d, rx_q, rx_d, rdata_q, rdata_d;
    logic          samp_q, samp_d, err_next_q, err_next_d, ack_err_q, ack_err_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          pend_q, pend_d;
    logic          scl_q, scl_d, sda_low_q, sda_low_d;
    logic          tick, samp_pt, bit_end, retry_ok, sda_in;
    logic [1:0]    qtr;

    assign busy_o    = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done_o    = (state_q == ST_DONE);
    assign ack_err_o = ack_err_q;
    assign rdata_o   = rdata_q;
    assign scl_o     = scl_q;
    assign sda_io    = sda_low_q ? 1'b0 : 1'bz;
    assign sda_in    = sda_io;

    i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .en_i      (busy_o),
        .tick_o    (tick),
        .quarter_o (qtr)
    );

    assign samp_pt = tick && (qtr == 2'd2);
    assign bit_end = tick && (qtr == Q_LAST);

`ifdef I2C_RETRY_EN
    assign retry_ok = (retry_q < RW'(RETRY_MAX));
`else
    assign retry_ok = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        rw_d       = rw_q;
        slv_d      = slv_q;
        reg_d      = reg_q;
        wd_d       = wd_q;
        idx_d      = idx_q;
        bit_d      = bit_q;
        sh_d       = sh_q;
        rx_d       = rx_q;
        rdata_d    = rdata_q;
        samp_d     = samp_q;
        err_next_d = err_next_q;
        ack_err_d  = ack_err_q;
        retry_d    = retry_q;
        pend_d     = pend_q;
        case (state_q)
            ST_IDLE: if (start_i) begin
                rw_d       = rw_i;
                slv_d      = slv_addr_i;
                reg_d      = reg_addr_i;
                wd_d       = wdata_i;
                idx_d      = '0;
                retry_d    = '0;
                pend_d     = 1'b0;
                err_next_d = 1'b0;
                state_d    = ST_START;
            end
            ST_START: if (bit_end) begin
                sh_d    = frame_byte(idx_q, rw_q, slv_q, reg_q, wd_q);
                bit_d   = '0;
                state_d = ST_TX_BYTE;
            end
            ST_TX_BYTE: if (bit_end) begin
                if (bit_q == 3'd7) begin
                    state_d = ST_RX_ACK;
                end else begin
                    bit_d = bit_q + 3'd1;
                    sh_d  = {sh_q[6:0], 1'b0};
                end
            end
            ST_RX_ACK: begin
                if (samp_pt) samp_d = sda_in;
                if (bit_end) begin
                    if (samp_q) begin
                        // NACK: either schedule another attempt or report it
                        if (retry_ok) begin
                            retry_d = retry_q + 1'b1;
                            pend_d  = 1'b1;
                        end else begin
                            err_next_d = 1'b1;
                        end
                        state_d = ST_STOP;
                    end else if (idx_q == LAST_BYTE) begin
                        state_d = ST_STOP;
                    end else if (idx_q == LAST_BYTE - 2'd1 && rw_q) begin
                        bit_d   = '0;
                        state_d = ST_RX_BYTE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        sh_d    = frame_byte(idx_q + 2'd1, rw_q, slv_q, reg_q, wd_q);
                        bit_d   = '0;
                        state_d = ST_TX_BYTE;
                    end
                end
            end
            ST_RX_BYTE: begin
                if (samp_pt) rx_d = {rx_q[6:0], sda_in};
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        rdata_d = rx_q;
                        state_d = ST_TX_NACK;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            ST_TX_NACK: if (bit_end) state_d = ST_STOP;
            ST_STOP: if (bit_end) begin
                if (pend_q) begin
                    pend_d  = 1'b0;
                    state_d = ST_GAP;
                end else begin
                    ack_err_d = err_next_q;
                    state_d   = ST_DONE;
                end
            end
            ST_GAP: if (bit_end) begin
                idx_d   = '0;
                state_d = ST_START;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus pin decode; SDA otherwise holds so data only moves at q1.
    always_comb begin
        scl_d     = 1'b1;
        sda_low_d = sda_low_q;
        case (state_q)
            ST_START: begin
                scl_d     = (qtr != 2'd3);
                sda_low_d = qtr[1];
            end
            ST_TX_BYTE: begin
                scl_d = qtr[1];
                if (qtr == 2'd1) sda_low_d = ~sh_q[7];
            end
            ST_RX_ACK, ST_RX_BYTE, ST_TX_NACK: begin
                scl_d = qtr[1];
                if (qtr == 2'd1) sda_low_d = 1'b0;
            end
            ST_STOP: begin
                scl_d     = qtr[1];
                sda_low_d = (qtr != 2'd3);
            end
            default: begin
                scl_d     = 1'b1;
                sda_low_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            rw_q       <= 1'b0;
            slv_q      <= '0;
            reg_q      <= '0;
            wd_q       <= '0;
            idx_q      <= '0;
            bit_q      <= '0;
            sh_q       <= '0;
            rx_q       <= '0;
            rdata_q    <= '0;
            samp_q     <= 1'b0;
            err_next_q <= 1'b0;
            ack_err_q  <= 1'b0;
            retry_q    <= '0;
            pend_q     <= 1'b0;
            scl_q      <= 1'b1;
            sda_low_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rw_q       <= rw_d;
            slv_q      <= slv_d;
            reg_q      <= reg_d;
            wd_q       <= wd_d;
            idx_q      <= idx_d;
            bit_q      <= bit_d;
            sh_q       <= sh_d;
            rx_q       <= rx_d;
            rdata_q    <= rdata_d;
            samp_q     <= samp_d;
            err_next_q <= err_next_d;
            ack_err_q  <= ack_err_d;
            retry_q    <= retry_d;
            pend_q     <= pend_d;
            scl_q      <= scl_d;
            sda_low_q  <= sda_low_d;
        end
    end

endmodule

// File: tb/tb_i2c_master_10b.sv
// Bench for i2c_master_10b: a register-file target at address 0x001 on the
// bus, a vector table of transactions, and a byte scoreboard per transfer.
module tb_i2c_master_10b;
    localparam int CLK_DIV   = 4;
    localparam int RETRY_MAX = 2;
`ifdef I2C_RETRY_EN
    localparam int ATT = RETRY_MAX + 1;
`else
    localparam int ATT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst, start, rw;
    logic [9:0] slv;
    logic [7:0] rega, wd;
    wire        busy, done, ack_err, scl;
    wire  [7:0] rdata;
    wire        sda;
    logic       tgt_low;

    pullup (sda);
    assign sda = tgt_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_master_10b #(.CLK_DIV(CLK_DIV), .RETRY_MAX(RETRY_MAX)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .rw_i(rw),
        .slv_addr_i(slv), .reg_addr_i(rega), .wdata_i(wd),
        .busy_o(busy), .done_o(done), .ack_err_o(ack_err), .rdata_o(rdata),
        .sda_io(sda), .scl_o(scl)
    );

    // ---------------- target model (address 0x001, 16 registers) ----------
    logic [7:0] mem [0:15];
    logic [7:0] obs_q [$];
    int         n_starts;
    logic       mack_bit;

    initial begin
        logic       pscl, psda, tx, act, rwb;
        int         nrise, byte_no;
        logic [7:0] sh, txb;
        logic [3:0] ptr;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        tgt_low = 1'b0; n_starts = 0; mack_bit = 1'b0;
        pscl = 1'b1; psda = 1'b1; tx = 1'b0; act = 1'b0; rwb = 1'b0;
        nrise = 0; byte_no = 0; sh = 8'h00; txb = 8'h00; ptr = 4'h0;
        forever begin
            @(negedge clk);
            if (pscl && scl && psda && !sda) begin
                n_starts++; nrise = 0; byte_no = 0; tx = 1'b0; act = 1'b1; tgt_low = 1'b0;
            end else if (pscl && scl && !psda && sda) begin
                act = 1'b0; tx = 1'b0; tgt_low = 1'b0;
            end else if (!pscl && scl) begin
                nrise++;
                if (nrise <= 8) sh = {sh[6:0], sda};
                else if (tx) mack_bit = sda;
            end else if (pscl && !scl && nrise > 0) begin
                if (nrise == 8) begin
                    obs_q.push_back(sh);
                    if (tx) tgt_low = 1'b0;
                    else begin
                        logic ack;
                        ack = 1'b0;
                        if (act) begin
                            case (byte_no)
                                0: begin ack = (sh[7:1] == 7'b1111000); rwb = sh[0]; end
                                1: ack = (sh == 8'h01);
                                2: begin ack = (sh < 8'd16); ptr = sh[3:0]; end
                                default: begin ack = 1'b1; mem[ptr] = sh; end
                            endcase
                        end
                        act = ack; tgt_low = ack;
                    end
                end else if (nrise == 9) begin
                    nrise = 0; byte_no++; tgt_low = 1'b0;
                    tx = act && rwb && (byte_no == 3);
                    if (tx) begin txb = mem[ptr]; tgt_low = ~txb[7]; end
                end else if (tx) begin
                    tgt_low = ~txb[7 - nrise];
                end
            end
            pscl = scl; psda = sda;
        end
    end

    // ---------------- checking ----------------
    int n_chk = 0, n_pass = 0;
    logic [7:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        n_chk++;
        if (act_v === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act_v, exp_v);
    endtask

    typedef struct {
        logic       rw;
        logic [9:0] slv;
        logic [7:0] ra, wd;
        int         nack;      // byte index that is NACKed, -1 = none
        logic       exp_err;
        logic [7:0] exp_rd;
        int         exp_lat;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [9:0] s, input logic [7:0] ra,
                                input logic [7:0] w, input int nk, input logic [7:0] rd);
        vec_t v;
        int   bits;
        v.rw = r; v.slv = s; v.ra = ra; v.wd = w; v.nack = nk;
        v.exp_err = (nk >= 0); v.exp_rd = rd;
        bits = (nk < 0) ? 38 : (ATT * (9 * (nk + 1) + 2) + (ATT - 1));
        v.exp_lat = bits * 4 * CLK_DIV;
        return v;
    endfunction

    function automatic logic [7:0] bus_byte(input vec_t v, input int k);
        logic [7:0] b;
        case (k)
            0: b = {5'b11110, v.slv[9:8], v.rw};
            1: b = v.slv[7:0];
            2: b = v.ra;
            default: b = v.rw ? v.exp_rd : v.wd;
        endcase
        return b;
    endfunction

    task automatic push_expected(input vec_t v);
        if (v.nack < 0) for (int k = 0; k < 4; k++) exp_q.push_back(bus_byte(v, k));
        else for (int a = 0; a < ATT; a++)
            for (int k = 0; k <= v.nack; k++) exp_q.push_back(bus_byte(v, k));
    endtask

    // Accept one transaction and wait (bounded) for done.
    task automatic run(input vec_t v, input bit ignore_mid, output int lat);
        rw = v.rw; slv = v.slv; rega = v.ra; wd = v.wd; start = 1'b1;
        push_expected(v);
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_accept", busy, 1'b1);
        lat = -1;
        for (int c = 1; c <= 8000; c++) begin
            if (ignore_mid && c == 100) begin
                rw = 1'b1; slv = 10'h2AA; rega = 8'h07; wd = 8'h99; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin lat = c; break; end
        end
        start = 1'b0;
        if (lat < 0) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain_scoreboard(input string tag);
        chk({tag, "_nbytes"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0)
            chk({tag, "_byte"}, obs_q.pop_front(), exp_q.pop_front());
        obs_q.delete(); exp_q.delete();
    endtask

    vec_t vecs [10];

    initial begin
        int lat, s0, cnt;
        vecs[0] = mk(1'b0, 10'h001, 8'h05, 8'hA5, -1, 8'h00);
        vecs[1] = mk(1'b1, 10'h001, 8'h05, 8'h00, -1, 8'hA5);
        vecs[2] = mk(1'b0, 10'h002, 8'h05, 8'h3C,  1, 8'hA5);
        vecs[3] = mk(1'b0, 10'h001, 8'h20, 8'h77,  2, 8'hA5);
        vecs[4] = mk(1'b0, 10'h001, 8'h0F, 8'h5A, -1, 8'hA5);
        vecs[5] = mk(1'b1, 10'h001, 8'h0F, 8'h00, -1, 8'h5A);
        vecs[6] = mk(1'b1, 10'h002, 8'h0F, 8'h00,  1, 8'h5A);
        vecs[7] = mk(1'b1, 10'h001, 8'h20, 8'h00,  2, 8'h5A);
        vecs[8] = mk(1'b0, 10'h101, 8'h01, 8'h01,  0, 8'h5A);
        vecs[9] = mk(1'b1, 10'h3FF, 8'h00, 8'h00,  0, 8'h5A);

        rst = 1'b1; start = 1'b0; rw = 1'b0; slv = '0; rega = '0; wd = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_scl", scl, 1'b1);
        chk("rst_sda", sda, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ack_err", ack_err, 1'b0);
        chk("rst_rdata", rdata, 8'h00);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            s0 = n_starts;
            mack_bit = 1'b0;
            run(vecs[i], 1'b0, lat);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("v%0d_ack_err", i), ack_err, vecs[i].exp_err);
            chk($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rd);
            chk($sformatf("v%0d_busy_in_done", i), busy, 1'b0);
            chk($sformatf("v%0d_starts", i), n_starts - s0, (vecs[i].nack >= 0) ? ATT : 1);
            if (vecs[i].rw && vecs[i].nack < 0) chk($sformatf("v%0d_master_nack", i), mack_bit, 1'b1);
            if (i == 0) chk("mem5_written", mem[5], 8'hA5);
            if (i == 3) chk("mem0_untouched", mem[0], 8'h00);
            @(posedge clk); #1;
            chk($sformatf("v%0d_done_pulse", i), done, 1'b0);
            drain_scoreboard($sformatf("v%0d", i));
        end

        // start pulse 100 cycles into a busy write, then start during DONE
        run(mk(1'b0, 10'h001, 8'h03, 8'h11, -1, 8'h5A), 1'b1, lat);
        chk("ign_latency", lat, 608);
        chk("ign_mem3", mem[3], 8'h11);
        chk("ign_mem7", mem[7], 8'h00);
        start = 1'b1; rw = 1'b0; slv = 10'h001; rega = 8'h07; wd = 8'h99;
        @(posedge clk); #1;
        start = 1'b0;
        chk("done_cycle_start_busy", busy, 1'b0);
        @(posedge clk); #1;
        chk("done_cycle_start_idle", busy, 1'b0);
        drain_scoreboard("ign");

        // reset in the middle of the first byte
        rw = 1'b0; slv = 10'h001; rega = 8'h09; wd = 8'hEE; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_scl", scl, 1'b1);
        chk("midrst_sda", sda, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_rdata", rdata, 8'h00);
        rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < 700; c++) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
        chk("midrst_no_done", cnt, 0);
        chk("midrst_mem9", mem[9], 8'h00);
        drain_scoreboard("midrst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
